audio_sample_arbiter: RTL
=========================

// Module: audio_sample_arbiter
// PURPOSE
//  Shares the single 16-bit sound path feeding i2s_audio_out between n_req sample producers
//  (tone generator, mic loopback, buzzer melody, ...). Paces transfers at a fixed sample rate.
//  Grants one owner at a time, round-robin, and holds the grant while the owner keeps streaming.
//  Sits between lab logic and the audio output stage; its sound output drives i2s data_in.
// PARAMETERS
//  clk_mhz        50     system clock frequency, MHz
//  sample_rate_hz 48000  output sample rate; tick period P = clk_mhz*1_000_000/sample_rate_hz (floor)
//  n_req          3      number of requesters, 2..8
//  w_sample       16     sample width, signed two's complement
//  release_ticks  4      consecutive underrun ticks before the owner loses its grant, >=1
// PORTS
//  clk         in   1                clock
//  rst         in   1                reset, asynchronous, active-high
//  req_valid   in   n_req            requester i has a sample ready
//  req_sample  in   n_req*w_sample   requester i sample, slice [i*w_sample +: w_sample]
//  req_ready   out  n_req            sample of requester i accepted this cycle
//  grant       out  n_req            one-hot current owner, all-zero when idle
//  sound       out  w_sample         sample to the audio output stage
//  sample_stb  out  1                one-cycle pulse: sound updated this cycle
//  underrun    out  1                one-cycle pulse: owner had no sample at a tick
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, grant=0, sound=0, req_ready=0, sample_stb=0,
//   underrun=0, tick counter=0, underrun counter=0, rr pointer=0. This holds mid-transfer too.
//   Nothing pending survives reset.
//  Tick: counter runs 0..P-1, tick=1 in the cycle count==P-1, then wraps to 0. It runs in every state.
//  Transfer rule: a sample moves when req_valid[i] && req_ready[i] in the same cycle.
//   req_ready[i] can be 1 only in a tick cycle and only for the granted index, so at most one bit is set.
//  IDLE: sound is driven to 0 (mute) and grant=0.
//   At a tick, if any req_valid is set, the winner is the first valid index searching from rr,
//   rr+1, ... with wrap modulo n_req.
//   In that same cycle: grant becomes the winner, req_ready[winner]=1, and the sample is
//   accepted. Next state is OWNED.
//   At a tick with no valid request: no change.
//  OWNED, at a tick:
//   owner valid -> req_ready[owner]=1 and accept; underrun counter=0.
//   owner not valid -> no accept and sound holds its last value; underrun pulses the next
//    cycle and the underrun counter increments.
//    When the counter reaches release_ticks: grant=0, rr=(owner+1) mod n_req, sound=0,
//    next state IDLE. The newly idle arbiter waits for the next tick before granting again.
//   Requests from non-owners are ignored while OWNED; there is no pre-emption.
//  Output timing: an accepted sample is registered into sound one cycle after the tick cycle.
//   sample_stb pulses in that same cycle. It also pulses on underrun-hold and release cycles,
//   because sound is re-presented or muted then.
//  Simultaneous valid requests at an IDLE tick: the round-robin order decides. Losers see no
//   req_ready and must hold their valid.
//  Dropping req_valid between ticks has no effect; only the tick-cycle value counts.
//  Widths: sound is copied unmodified. No mixing and no scaling.
// STRUCTURE
//  Package audio_arb_pkg: state enum {IDLE, OWNED}; function clog2-safe index width;
//   function computing tick period P.
//  Sub-module sample_tick_gen (clk, rst, tick), parameterised by clk_mhz and sample_rate_hz.
//   Reused by other audio blocks.
//  Arbiter core: registers for state, owner index, rr pointer, underrun counter, sound,
//   and the strobes.
// TESTING (clk_mhz=1, sample_rate_hz=100000 -> P=10; n_req=3, release_ticks=2)
//  1 Reset mid-OWNED:
//    rst pulsed between clock edges -> grant=0, sound=0 and all strobes 0 immediately.
//    The first tick comes 10 cycles after release.
//  2 Only req 1 valid, samples 16'h1234 then 16'h8001:
//    req_ready[1] appears at ticks only; sound=1234 one cycle after the first tick.
//    sound=8001 one cycle after the next tick; sample_stb matches each update.
//  3 All three valid at an IDLE tick, rr=0:
//    grant=3'b001; req 1 and req 2 never get req_ready while req 0 streams.
//  4 Owner 0 drops valid for 2 ticks:
//    sound holds its last value after tick 1 and underrun pulses;
//    after tick 2 grant=0, sound=0 and rr=1. At the next tick req 1 wins over req 0.
//  5 Owner drops valid for 1 tick only, then resumes:
//    one underrun pulse, the grant is kept, the counter resets, and streaming continues.
//  6 req_valid pulsed only between ticks:
//    no req_ready and no grant; the arbiter stays IDLE with sound=0.

Source files
------------

// File: rtl/audio_arb_pkg.sv
// Shared types and elaboration-time helpers for the audio sample arbiter
// and its tick generator.
//   arb_state_e  : arbiter FSM encoding
//   idx_width()  : bits needed to hold an index 0..n-1, never less than 1
//   tick_period(): system clocks per output sample, floored, never less than 1
package audio_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tick_period(input int clk_mhz, input int rate_hz);
        int p;
        p = (clk_mhz * 1_000_000) / rate_hz;
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator shared by the audio blocks.
// A free-running counter walks 0..P-1; tick is high for the single cycle in
// which the counter sits at P-1, then the counter wraps to 0.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (counter to 0)
//   tick  out  one-cycle pulse every P clocks
module sample_tick_gen
    import audio_arb_pkg::*;
#(
    parameter int clk_mhz        = 50,
    parameter int sample_rate_hz = 48000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int P  = tick_period(clk_mhz, sample_rate_hz);
    localparam int CW = idx_width(P);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(P - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_sample_arbiter.sv
// Round-robin arbiter sharing one sample path between n_req producers.
// One transfer per sample tick; the owner keeps the grant while it streams
// and loses it after release_ticks consecutive ticks without a sample.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ARB_IDLE  | no owner, sound muted; next tick with any valid grants
//   ARB_OWNED | owner_q streams one sample per tick, others ignored
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req_valid   per-requester sample available
//   req_sample  packed samples, requester i at [i*w_sample +: w_sample]
//   req_ready   per-requester accept (tick cycle, granted index only)
//   grant       one-hot owner, zero when idle
//   sound       sample to the audio output stage
//   sample_stb  pulse: sound re-presented this cycle
//   underrun    pulse: owner had no sample at the previous tick
module audio_sample_arbiter
    import audio_arb_pkg::*;
#(
    parameter int clk_mhz        = 50,
    parameter int sample_rate_hz = 48000,
    parameter int n_req          = 3,
    parameter int w_sample       = 16,
    parameter int release_ticks  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_req-1:0]          req_valid,
    input  logic [n_req*w_sample-1:0] req_sample,
    output logic [n_req-1:0]          req_ready,
    output logic [n_req-1:0]          grant,
    output logic [w_sample-1:0]       sound,
    output logic                      sample_stb,
    output logic                      underrun
);

    localparam int IW = idx_width(n_req);
    localparam int UW = idx_width(release_ticks + 1);

    logic tick;

    sample_tick_gen #(
        .clk_mhz        (clk_mhz),
        .sample_rate_hz (sample_rate_hz)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [UW-1:0]       urun_cnt_q, urun_cnt_d;
    logic [w_sample-1:0] sound_q, sound_d;
    logic                stb_q, stb_d;
    logic                underrun_q, underrun_d;

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic                accept;
    logic [IW-1:0]       acc_idx;
    logic [w_sample-1:0] sel_sample;

    // First valid requester searching upward from the rr pointer, wrapping.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = rr_q;
        for (int k = 0; k < n_req; k++) begin
            j = int'(rr_q) + k;
            if (j >= n_req) j = j - n_req;
            if (!win_found && req_valid[IW'(j)]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        urun_cnt_d = urun_cnt_q;
        sound_d    = sound_q;
        stb_d      = 1'b0;
        underrun_d = 1'b0;
        accept     = 1'b0;
        acc_idx    = owner_q;

        case (state_q)
            ARB_IDLE: begin
                sound_d = '0;
                if (tick && win_found) begin
                    accept     = 1'b1;
                    acc_idx    = win_idx;
                    owner_d    = win_idx;
                    urun_cnt_d = '0;
                    state_d    = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (tick) begin
                    if (req_valid[owner_q]) begin
                        accept     = 1'b1;
                        urun_cnt_d = '0;
                    end else begin
                        // Missed tick: sound is re-presented (or muted on release).
                        underrun_d = 1'b1;
                        stb_d      = 1'b1;
                        if (urun_cnt_q == UW'(release_ticks - 1)) begin
                            urun_cnt_d = '0;
                            sound_d    = '0;
                            rr_d       = (owner_q == IW'(n_req - 1)) ? '0 : owner_q + 1'b1;
                            state_d    = ARB_IDLE;
                        end else begin
                            urun_cnt_d = urun_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        sel_sample = '0;
        for (int i = 0; i < n_req; i++) begin
            if (acc_idx == IW'(i)) sel_sample = req_sample[i*w_sample +: w_sample];
        end

        if (accept) begin
            sound_d = sel_sample;
            stb_d   = 1'b1;
        end
    end

    // The IDLE winner is shown on grant in its tick cycle so that req_ready
    // never asserts for an index that is not granted.
    always_comb begin
        for (int i = 0; i < n_req; i++) begin
            req_ready[i] = accept && (acc_idx == IW'(i));
            grant[i]     = (state_q == ARB_OWNED) ? (owner_q == IW'(i))
                                                  : (accept && (acc_idx == IW'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            urun_cnt_q <= '0;
            sound_q    <= '0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            urun_cnt_q <= urun_cnt_d;
            sound_q    <= sound_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    assign sound      = sound_q;
    assign sample_stb = stb_q;
    assign underrun   = underrun_q;

endmodule
